// File: rtl/risc_mem_sequencer.sv
// Fetch/execute sequencer for the 8-bit accumulator CPU: owns PC, IR and the
// memory address mux, and walks a fixed 8-phase cycle per instruction.
module risc_mem_sequencer #(
    parameter int AW  = 5,
    parameter int DW  = 8,
    parameter int OPW = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [DW-1:0]  data_in,
    input  logic [DW-1:0]  acc,
    input  logic           zero,
    output logic [AW-1:0]  addr,
    output logic           mem_rd,
    output logic           mem_wr,
    output logic [DW-1:0]  data_out,
    output logic           data_oe,
    output logic [OPW-1:0] alu_op,
    output logic           ld_acc,
    output logic           halt,
    output logic [AW-1:0]  pc_q,
    output logic [DW-1:0]  ir_q
);

    typedef enum logic [2:0] {
        PH_INST_ADDR  = 3'd0,
        PH_INST_FETCH = 3'd1,
        PH_INST_LOAD  = 3'd2,
        PH_IDLE       = 3'd3,
        PH_OP_ADDR    = 3'd4,
        PH_OP_FETCH   = 3'd5,
        PH_ALU_OP     = 3'd6,
        PH_STORE      = 3'd7
    } phase_t;

    localparam logic [OPW-1:0] OP_HLT = OPW'(0);
    localparam logic [OPW-1:0] OP_SKZ = OPW'(1);
    localparam logic [OPW-1:0] OP_ADD = OPW'(2);
    localparam logic [OPW-1:0] OP_AND = OPW'(3);
    localparam logic [OPW-1:0] OP_XOR = OPW'(4);
    localparam logic [OPW-1:0] OP_LDA = OPW'(5);
    localparam logic [OPW-1:0] OP_STO = OPW'(6);
    localparam logic [OPW-1:0] OP_JMP = OPW'(7);

    phase_t          phase, phase_n;
    logic [AW-1:0]   pc, pc_n;
    logic [DW-1:0]   ir, ir_n;
    logic            halt_r, halt_n;
    logic [OPW-1:0]  opcode;
    logic [AW-1:0]   operand;
    logic            aluop_cls;
    logic            is_sto;

    assign opcode    = ir[DW-1:DW-OPW];
    assign operand   = ir[AW-1:0];
    assign aluop_cls = (opcode == OP_ADD) || (opcode == OP_AND) ||
                       (opcode == OP_XOR) || (opcode == OP_LDA);
    assign is_sto    = (opcode == OP_STO);

    // All state is async-reset, so every decoded strobe drops with rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase  <= PH_INST_ADDR;
            pc     <= '0;
            ir     <= '0;
            halt_r <= 1'b0;
        end else begin
            phase  <= phase_n;
            pc     <= pc_n;
            ir     <= ir_n;
            halt_r <= halt_n;
        end
    end

    always_comb begin
        phase_n = phase;
        pc_n    = pc;
        ir_n    = ir;
        halt_n  = halt_r;
        if (!halt_r) begin
            phase_n = phase_t'(phase + 3'd1);
            case (phase)
                PH_INST_LOAD, PH_IDLE: ir_n = data_in;
                PH_OP_ADDR: begin
                    pc_n = pc + AW'(1);
                    if (opcode == OP_HLT) halt_n = 1'b1;
                end
                // Jump load wins over the SKZ increment in phase 6.
                PH_ALU_OP: begin
                    if (opcode == OP_JMP)
                        pc_n = operand;
                    else if (opcode == OP_SKZ && zero)
                        pc_n = pc + AW'(1);
                end
                PH_STORE: if (opcode == OP_JMP) pc_n = operand;
                default: ;
            endcase
        end
    end

    always_comb begin
        addr    = phase[2] ? operand : pc;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        data_oe = 1'b0;
        ld_acc  = 1'b0;
        case (phase)
            PH_INST_FETCH, PH_INST_LOAD, PH_IDLE: mem_rd = 1'b1;
            PH_OP_FETCH: mem_rd = aluop_cls;
            PH_ALU_OP: begin
                mem_rd  = aluop_cls;
                data_oe = is_sto;
            end
            PH_STORE: begin
                mem_rd  = aluop_cls;
                data_oe = is_sto;
                mem_wr  = is_sto;
                ld_acc  = aluop_cls;
            end
            default: ;
        endcase
    end

    assign data_out = acc;
    assign alu_op   = opcode;
    assign halt     = halt_r;
    assign pc_q     = pc;
    assign ir_q     = ir;

endmodule

// File: tb/tb_risc_mem_sequencer.sv
// Bench for risc_mem_sequencer: memory and accumulator environment plus an
// instruction-level reference model checked phase by phase.
module tb_risc_mem_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in, acc, data_out, ir_q;
    logic       zero, mem_rd, mem_wr, data_oe, ld_acc, halt;
    logic [4:0] addr, pc_q;
    logic [2:0] alu_op;

    logic [7:0] mem     [32];
    logic [7:0] ref_mem [32];
    logic [7:0] ref_acc;
    logic [4:0] ref_pc;
    int n_checks = 0;
    int n_pass   = 0;

    risc_mem_sequencer dut (
        .clk(clk), .rst(rst), .data_in(data_in), .acc(acc), .zero(zero),
        .addr(addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .data_out(data_out),
        .data_oe(data_oe), .alu_op(alu_op), .ld_acc(ld_acc), .halt(halt),
        .pc_q(pc_q), .ir_q(ir_q)
    );

    always #5 clk = ~clk;

    // Environment: memory read bus, memory write port and accumulator/ALU.
    assign data_in = mem_rd ? mem[addr] : 8'h00;
    assign zero    = (acc == 8'h00);

    always @(posedge clk)
        if (mem_wr && data_oe) mem[addr] = data_out;

    always @(posedge clk or posedge rst) begin
        if (rst) acc <= 8'h00;
        else if (ld_acc) begin
            case (alu_op)
                3'b010: acc <= acc + data_in;
                3'b011: acc <= acc & data_in;
                3'b100: acc <= acc ^ data_in;
                3'b101: acc <= data_in;
                default: ;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic load(input int a, input logic [7:0] v);
        mem[a]     = v;
        ref_mem[a] = v;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " addr"},    32'(addr),    32'd0);
        check({tag, " pc_q"},    32'(pc_q),    32'd0);
        check({tag, " halt"},    32'(halt),    32'd0);
        check({tag, " mem_rd"},  32'(mem_rd),  32'd0);
        check({tag, " mem_wr"},  32'(mem_wr),  32'd0);
        check({tag, " data_oe"}, 32'(data_oe), 32'd0);
        check({tag, " ld_acc"},  32'(ld_acc),  32'd0);
        check({tag, " alu_op"},  32'(alu_op),  32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        ref_pc  = 5'd0;
        ref_acc = 8'h00;
        check_reset_state("reset");
    endtask

    // Runs one instruction from phase 0, checking every phase against the
    // instruction-level model; stops early before phase stop_at (8 = full).
    task automatic run_instr(input int stop_at, output bit halted);
        logic [7:0] ir;
        logic [2:0] op;
        logic [4:0] a, pc1, npc;
        bit         cls, sto, z;
        halted = 1'b0;
        ir  = ref_mem[ref_pc];
        op  = ir[7:5];
        a   = ir[4:0];
        cls = (op >= 3'd2) && (op <= 3'd5);
        sto = (op == 3'd6);
        z   = (ref_acc == 8'h00);
        pc1 = ref_pc + 5'd1;
        if (op == 3'd7)      npc = a;
        else if (op == 3'd1 && z) npc = pc1 + 5'd1;
        else                 npc = pc1;
        for (int p = 0; p < 8; p++) begin
            if (p == stop_at) return;
            if (op == 3'd0 && p == 5) begin
                for (int c = 0; c < 20; c++) begin
                    check("halt flag",    32'(halt),    32'd1);
                    check("halt pc_q",    32'(pc_q),    32'(pc1));
                    check("halt strobes", 32'({mem_rd, mem_wr, data_oe, ld_acc}), 32'd0);
                    @(negedge clk);
                end
                ref_pc = pc1;
                halted = 1'b1;
                return;
            end
            check($sformatf("p%0d addr", p),    32'(addr),    32'(p < 4 ? ref_pc : a));
            check($sformatf("p%0d mem_rd", p),  32'(mem_rd),  32'((p >= 1 && p <= 3) || (p >= 5 && cls)));
            check($sformatf("p%0d data_oe", p), 32'(data_oe), 32'(sto && p >= 6));
            check($sformatf("p%0d mem_wr", p),  32'(mem_wr),  32'(sto && p == 7));
            check($sformatf("p%0d ld_acc", p),  32'(ld_acc),  32'(cls && p == 7));
            check($sformatf("p%0d halt", p),    32'(halt),    32'd0);
            check($sformatf("p%0d pc_q", p),    32'(pc_q),    32'(p <= 4 ? ref_pc : (p <= 6 ? pc1 : npc)));
            if (p >= 3) begin
                check($sformatf("p%0d ir_q", p),   32'(ir_q),   32'(ir));
                check($sformatf("p%0d alu_op", p), 32'(alu_op), 32'(op));
            end
            if (sto && p >= 6)
                check($sformatf("p%0d data_out", p), 32'(data_out), 32'(ref_acc));
            @(negedge clk);
        end
        case (op)
            3'd2: ref_acc = ref_acc + ref_mem[a];
            3'd3: ref_acc = ref_acc & ref_mem[a];
            3'd4: ref_acc = ref_acc ^ ref_mem[a];
            3'd5: ref_acc = ref_mem[a];
            3'd6: ref_mem[a] = ref_acc;
            default: ;
        endcase
        ref_pc = npc;
    endtask

    initial begin
        bit halted;
        logic [7:0] v;
        for (int i = 0; i < 32; i++) load(i, 8'h00);
        // Directed program: LDA, STO, SKZ (not taken), XOR to zero, SKZ (taken),
        // JMP to 31, JMP wrapping 31->0 then to 7, HLT.
        load(0, 8'hA5); load(1, 8'hC9); load(2, 8'h20); load(3, 8'h85);
        load(4, 8'h20); load(5, 8'h3C); load(6, 8'hFF); load(7, 8'h00);
        load(31, 8'hE7);
        @(negedge clk);
        do_reset();
        halted = 1'b0;
        for (int n = 0; n < 12 && !halted; n++) run_instr(8, halted);
        check("directed reached halt", 32'(halted), 32'd1);
        check("halt pc after program", 32'(pc_q), 32'd8);
        check("STO readback mem[9]", 32'(mem[9]), 32'h3C);

        // Reset clears halt; then abort a STO mid-phase 6.
        do_reset();
        load(9, 8'h77);
        run_instr(8, halted);
        run_instr(6, halted);
        check("pre-abort data_oe", 32'(data_oe), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("abort data_oe async", 32'(data_oe), 32'd0);
        check("abort mem_wr async",  32'(mem_wr),  32'd0);
        check("abort addr async",    32'(addr),    32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        ref_pc  = 5'd0;
        ref_acc = 8'h00;
        check_reset_state("post-abort");
        check("aborted STO no write", 32'(mem[9]), 32'h77);
        load(9, 8'h77);

        // Randomized programs; halts are allowed and recovered with reset.
        for (int round = 0; round < 3; round++) begin
            for (int i = 0; i < 32; i++) begin
                v = 8'($urandom);
                if ($urandom_range(0, 9) == 0) v = 8'h00;
                else if (v[7:5] == 3'd0) v[7:5] = 3'($urandom_range(1, 7));
                load(i, v);
            end
            do_reset();
            for (int n = 0; n < 120; n++) begin
                run_instr(8, halted);
                if (halted) do_reset();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
